pmem_write_buffer: RTL and testbench

Line-granular write-back buffer between the cache arbiter's physical-memory port and physical memory. Cache evictions are absorbed in one response cycle and drained to memory when no request is pending. Reads hitting a buffered line are served from the buffer; reads that miss are forwarded to memory. The upstream side speaks the same read/write/resp handshake the arbiter already drives, so the block drops in transparently.

---
 rtl/pmem_write_buffer_pkg.sv | 29 ++
 rtl/pmem_write_buffer_store.sv | 76 +++++++
 rtl/pmem_write_buffer.sv | 115 +++++++++++
 tb/tb_pmem_write_buffer.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pmem_write_buffer_pkg.sv
// Shared types for the physical-memory write-back buffer: line/tag types,
// buffer entry layout, FSM state encoding and address helpers.
package pmem_write_buffer_pkg;

  typedef logic [127:0] lc3b_line;
  typedef logic [11:0]  lc3b_line_tag;

  typedef struct packed {
    logic         valid;
    lc3b_line_tag tag;
    lc3b_line     data;
  } wb_entry_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RD_MEM,
    S_DRAIN,
    S_RESP
  } wb_state_t;

  function automatic lc3b_line_tag addr_tag(input logic [15:0] addr);
    return addr[15:4];
  endfunction

  function automatic logic [15:0] line_addr(input lc3b_line_tag tag);
    return {tag, 4'b0000};
  endfunction

endpackage

// File: rtl/pmem_write_buffer_store.sv
// Entry array of the write buffer: FIFO head/tail/count bookkeeping plus a
// fully associative tag compare used for read hits and write coalescing.
module wbuf_store
  import pmem_write_buffer_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  lc3b_line_tag tag,
  input  logic         wr_en,
  input  lc3b_line     wr_data,
  input  logic         pop,
  output logic         hit,
  output lc3b_line     hit_data,
  output lc3b_line_tag head_tag,
  output lc3b_line     head_data,
  output logic         full,
  output logic         empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  wb_entry_t         entries_reg [DEPTH];
  logic [PW-1:0]     head_reg;
  logic [PW-1:0]     tail_reg;
  logic [CW-1:0]     count_reg;
  logic [DEPTH-1:0]  match;
  logic [PW-1:0]     hit_index;

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_match
      assign match[gi] = entries_reg[gi].valid && (entries_reg[gi].tag == tag);
    end
  endgenerate

  // Valid tags are unique, so at most one match bit is ever set.
  always_comb begin
    hit_index = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (match[i]) hit_index = PW'(i);
    end
  end

  assign hit       = |match;
  assign hit_data  = entries_reg[hit_index].data;
  assign head_tag  = entries_reg[head_reg].tag;
  assign head_data = entries_reg[head_reg].data;
  assign full      = (count_reg == CW'(DEPTH));
  assign empty     = (count_reg == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        entries_reg[i] <= '0;
      end
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= '0;
    end else if (pop) begin
      entries_reg[head_reg].valid <= 1'b0;
      head_reg  <= head_reg + PW'(1);
      count_reg <= count_reg - CW'(1);
    end else if (wr_en) begin
      if (hit) begin
        entries_reg[hit_index].data <= wr_data;
      end else begin
        entries_reg[tail_reg] <= '{valid: 1'b1, tag: tag, data: wr_data};
        tail_reg  <= tail_reg + PW'(1);
        count_reg <= count_reg + CW'(1);
      end
    end
  end

endmodule

// File: rtl/pmem_write_buffer.sv
// Write-back buffer between the cache arbiter and physical memory: absorbs
// evictions, serves read hits locally and drains lines when the port is idle.
module pmem_write_buffer
  import pmem_write_buffer_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          arb_read,
  input  logic          arb_write,
  input  logic [15:0]   arb_address,
  input  logic [127:0]  arb_wdata,
  output logic [127:0]  arb_rdata,
  output logic          arb_resp,
  output logic          pmem_read,
  output logic          pmem_write,
  output logic [15:0]   pmem_address,
  output logic [127:0]  pmem_wdata,
  input  logic [127:0]  pmem_rdata,
  input  logic          pmem_resp
);

  wb_state_t    state_reg;
  lc3b_line_tag req_tag;
  logic         hit;
  lc3b_line     hit_data;
  lc3b_line_tag head_tag;
  lc3b_line     head_data;
  logic         full;
  logic         empty;
  logic         store_wr;
  logic         store_pop;
  logic         addr_offset_unused;

  assign req_tag            = addr_tag(arb_address);
  assign addr_offset_unused = ^arb_address[3:0];

  // Store updates happen on the same edge the FSM accepts the write or
  // retires the drained head line.
  assign store_wr  = (state_reg == S_IDLE) && !arb_read && arb_write && (hit || !full);
  assign store_pop = (state_reg == S_DRAIN) && pmem_resp;

  wbuf_store #(.DEPTH(DEPTH)) u_store (
    .clk       (clk),
    .rst       (rst),
    .tag       (req_tag),
    .wr_en     (store_wr),
    .wr_data   (arb_wdata),
    .pop       (store_pop),
    .hit       (hit),
    .hit_data  (hit_data),
    .head_tag  (head_tag),
    .head_data (head_data),
    .full      (full),
    .empty     (empty)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= S_IDLE;
      arb_rdata    <= '0;
      arb_resp     <= 1'b0;
      pmem_read    <= 1'b0;
      pmem_write   <= 1'b0;
      pmem_address <= '0;
      pmem_wdata   <= '0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (arb_read) begin
            if (hit) begin
              arb_rdata <= hit_data;
              arb_resp  <= 1'b1;
              state_reg <= S_RESP;
            end else begin
              pmem_read    <= 1'b1;
              pmem_address <= line_addr(req_tag);
              state_reg    <= S_RD_MEM;
            end
          end else if (arb_write && (hit || !full)) begin
            arb_resp  <= 1'b1;
            state_reg <= S_RESP;
          end else if (arb_write || !empty) begin
            // A write to a full buffer frees the head first and is retried.
            pmem_write   <= 1'b1;
            pmem_address <= line_addr(head_tag);
            pmem_wdata   <= head_data;
            state_reg    <= S_DRAIN;
          end
        end
        S_RD_MEM: begin
          if (pmem_resp) begin
            pmem_read <= 1'b0;
            arb_rdata <= pmem_rdata;
            arb_resp  <= 1'b1;
            state_reg <= S_RESP;
          end
        end
        S_DRAIN: begin
          if (pmem_resp) begin
            pmem_write <= 1'b0;
            state_reg  <= S_IDLE;
          end
        end
        S_RESP: begin
          arb_resp  <= 1'b0;
          state_reg <= S_IDLE;
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pmem_write_buffer.sv
// Scoreboard bench for pmem_write_buffer: directed arbiter traffic, a simple
// memory responder, and a monitor checking every arb_resp and pmem transaction.
module tb_pmem_write_buffer;

  logic         clk;
  logic         rst;
  logic         arb_read;
  logic         arb_write;
  logic [15:0]  arb_address;
  logic [127:0] arb_wdata;
  logic [127:0] arb_rdata;
  logic         arb_resp;
  logic         pmem_read;
  logic         pmem_write;
  logic [15:0]  pmem_address;
  logic [127:0] pmem_wdata;
  logic [127:0] pmem_rdata;
  logic         pmem_resp;

  pmem_write_buffer #(.DEPTH(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .arb_read     (arb_read),
    .arb_write    (arb_write),
    .arb_address  (arb_address),
    .arb_wdata    (arb_wdata),
    .arb_rdata    (arb_rdata),
    .arb_resp     (arb_resp),
    .pmem_read    (pmem_read),
    .pmem_write   (pmem_write),
    .pmem_address (pmem_address),
    .pmem_wdata   (pmem_wdata),
    .pmem_rdata   (pmem_rdata),
    .pmem_resp    (pmem_resp)
  );

  localparam logic [127:0] DA = 128'hAAAA_0001_AAAA_0002_AAAA_0003_AAAA_0004;
  localparam logic [127:0] DB = 128'hBBBB_1111_BBBB_2222_BBBB_3333_BBBB_4444;
  localparam logic [127:0] DE = 128'hEEEE_5555_EEEE_6666_EEEE_7777_EEEE_8888;
  localparam logic [127:0] DF = 128'hFFFF_0F0F_FFFF_1F1F_FFFF_2F2F_FFFF_3F3F;

  typedef struct {
    bit           is_read;
    logic [127:0] data;
  } arb_exp_t;

  typedef struct {
    bit           is_write;
    logic [15:0]  addr;
    logic [127:0] data;
  } pmem_exp_t;

  arb_exp_t  exp_arb[$];
  pmem_exp_t exp_pmem[$];

  int total = 0;
  int bad   = 0;

  int mem_lat   = 2;
  bit mem_stall = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  // Memory model: answers a held request after mem_lat cycles with a one-cycle pulse.
  initial begin
    int cnt;
    cnt = 0;
    pmem_resp  = 1'b0;
    pmem_rdata = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        pmem_resp = 1'b0;
        cnt = 0;
      end else if (pmem_resp) begin
        pmem_resp = 1'b0;
        cnt = 0;
      end else if ((pmem_read || pmem_write) && !mem_stall) begin
        cnt++;
        if (cnt >= mem_lat) pmem_resp = 1'b1;
      end
    end
  end

  // Monitor: pops expectations whenever the DUT presents a response or starts a memory request.
  initial begin
    bit           prev_act;
    bit           act;
    logic [15:0]  held_addr;
    logic [127:0] held_data;
    arb_exp_t     ea;
    pmem_exp_t    ep;
    prev_act  = 0;
    held_addr = '0;
    held_data = '0;
    forever begin
      @(posedge clk);
      #1;
      if (rst) begin
        prev_act = 0;
      end else begin
        if (arb_resp) begin
          total++;
          if (exp_arb.size() == 0) begin
            bad++;
            $display("FAIL unexpected_arb_resp: got resp=1 rdata=%h expected no response", arb_rdata);
          end else begin
            ea = exp_arb.pop_front();
            if (ea.is_read && arb_rdata !== ea.data) begin
              bad++;
              $display("FAIL arb_rdata: got %h expected %h", arb_rdata, ea.data);
            end
          end
        end
        if (pmem_read && pmem_write) begin
          total++;
          bad++;
          $display("FAIL pmem_both: got read=1 write=1 expected at most one");
        end
        act = pmem_read || pmem_write;
        if (act && !prev_act) begin
          total++;
          held_addr = pmem_address;
          held_data = pmem_wdata;
          if (exp_pmem.size() == 0) begin
            bad++;
            $display("FAIL unexpected_pmem: got %s addr=%h expected no request",
                     pmem_write ? "write" : "read", pmem_address);
          end else begin
            ep = exp_pmem.pop_front();
            if (pmem_write !== ep.is_write || pmem_address !== ep.addr ||
                (ep.is_write && pmem_wdata !== ep.data)) begin
              bad++;
              $display("FAIL pmem_txn: got %s addr=%h data=%h expected %s addr=%h data=%h",
                       pmem_write ? "write" : "read", pmem_address, pmem_wdata,
                       ep.is_write ? "write" : "read", ep.addr, ep.data);
            end else begin
              $display("pmem %s addr=%h data=%h", ep.is_write ? "write" : "read",
                       pmem_address, pmem_wdata);
            end
          end
        end else if (act && prev_act) begin
          total++;
          if (pmem_address !== held_addr || pmem_wdata !== held_data) begin
            bad++;
            $display("FAIL pmem_stable: got addr=%h data=%h expected addr=%h data=%h",
                     pmem_address, pmem_wdata, held_addr, held_data);
          end
        end
        prev_act = act;
      end
    end
  end

  // Issue one arbiter request and hold it until arb_resp; exp_lat<0 skips the latency check.
  task automatic arb_req(input bit rd, input logic [15:0] addr, input logic [127:0] wdata,
                         input logic [127:0] exp_rdata, input int exp_lat, input string name);
    int waits;
    exp_arb.push_back('{is_read: rd, data: exp_rdata});
    @(negedge clk);
    arb_read    = rd;
    arb_write   = !rd;
    arb_address = addr;
    arb_wdata   = wdata;
    waits = 0;
    do begin
      @(negedge clk);
      waits++;
    end while (!arb_resp && waits < 200);
    arb_read  = 1'b0;
    arb_write = 1'b0;
    $display("arb %s %s addr=%h cycles=%0d", name, rd ? "read" : "write", addr, waits);
    if (exp_lat >= 0 || !arb_resp) begin
      total++;
      if (!arb_resp || waits != exp_lat) begin
        bad++;
        $display("FAIL %s_latency: got %0d cycles (resp=%0b) expected %0d", name, waits,
                 arb_resp, exp_lat);
      end
    end
  endtask

  task automatic wait_quiet(input int extra, input string name);
    int n;
    n = 0;
    while ((exp_pmem.size() != 0 || pmem_read || pmem_write) && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (n >= 500) begin
      total++;
      bad++;
      $display("FAIL %s_drain_timeout: got %0d pending expected 0", name, exp_pmem.size());
    end
    repeat (extra) @(negedge clk);
  endtask

  initial begin
    int n;
    rst         = 1'b1;
    arb_read    = 1'b0;
    arb_write   = 1'b0;
    arb_address = '0;
    arb_wdata   = '0;

    // Reset state and a quiet idle period
    repeat (3) @(negedge clk);
    chk("rst_arb_resp", {127'b0, arb_resp}, 128'd0);
    chk("rst_pmem_read", {127'b0, pmem_read}, 128'd0);
    chk("rst_pmem_write", {127'b0, pmem_write}, 128'd0);
    chk("rst_arb_rdata", arb_rdata, 128'd0);
    chk("rst_pmem_address", {112'b0, pmem_address}, 128'd0);
    chk("rst_pmem_wdata", pmem_wdata, 128'd0);
    rst = 1'b0;
    repeat (20) @(negedge clk);

    // Single write drains once the port goes idle
    mem_lat = 2;
    exp_pmem.push_back('{is_write: 1, addr: 16'h1230, data: DA});
    arb_req(0, 16'h1230, DA, '0, 1, "wr_1230");
    wait_quiet(5, "single");

    // Read hit served from the buffer before the drain
    exp_pmem.push_back('{is_write: 1, addr: 16'h1230, data: DA});
    arb_req(0, 16'h1230, DA, '0, 1, "wr_1230b");
    arb_req(1, 16'h1234, '0, DA, 1, "rd_hit_1234");
    wait_quiet(5, "hit");

    // Coalescing: two writes to one line, one drain with the newer data
    exp_pmem.push_back('{is_write: 1, addr: 16'h2000, data: DB});
    arb_req(0, 16'h2000, DA, '0, 1, "wr_2000a");
    arb_req(0, 16'h2000, DB, '0, 1, "wr_2000b");
    wait_quiet(5, "coalesce");

    // Fill to DEPTH with memory stalled, then a fifth write forces one drain
    mem_stall = 1;
    for (int i = 0; i < 5; i++) begin
      exp_pmem.push_back('{is_write: 1, addr: 16'(i * 16), data: DA ^ 128'(i)});
    end
    for (int i = 0; i < 4; i++) begin
      arb_req(0, 16'(i * 16), DA ^ 128'(i), '0, 1, $sformatf("fill_%0d", i));
    end
    mem_lat   = 3;
    mem_stall = 0;
    arb_req(0, 16'h0040, DA ^ 128'd4, '0, 5, "wr_full_0040");
    wait_quiet(5, "fifo");

    // Read miss bypasses the buffered line, which drains afterwards
    mem_lat    = 2;
    pmem_rdata = DE;
    exp_pmem.push_back('{is_write: 0, addr: 16'h4000, data: '0});
    exp_pmem.push_back('{is_write: 1, addr: 16'h5000, data: DF});
    arb_req(0, 16'h5000, DF, '0, 1, "wr_5000");
    arb_req(1, 16'h4000, '0, DE, 3, "rd_miss_4000");
    mem_stall = 1;
    n = 0;
    while (!pmem_write && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("drain_5000_started", {127'b0, pmem_write}, 128'd1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rst_mid_drain_pmem_write", {127'b0, pmem_write}, 128'd0);
    chk("rst_mid_drain_pmem_address", {112'b0, pmem_address}, 128'd0);
    @(negedge clk);
    rst       = 1'b0;
    mem_stall = 0;
    repeat (20) @(negedge clk);

    chk("exp_arb_empty", 128'(exp_arb.size()), 128'd0);
    chk("exp_pmem_empty", 128'(exp_pmem.size()), 128'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
